// File: rtl/vga_timing_gen_if.sv
// Bundle between the raster timing generator and its colour mapper / DAC pins.
// The master drives the scan position and the DAC outputs; the slave returns colour.
interface vga_timing_gen_if;
  logic [7:0] Red;
  logic [7:0] Green;
  logic [7:0] Blue;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       frame_start;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;

  modport master (
    input  Red, Green, Blue,
    output DrawX, DrawY, frame_start,
    output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
    output VGA_R, VGA_G, VGA_B
  );

  modport slave (
    output Red, Green, Blue,
    input  DrawX, DrawY, frame_start,
    input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
    input  VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divides the system clock to a pixel enable, scans DrawX/DrawY,
// and registers the returned colour together with sync/blank so the DAC sees them aligned.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic             Clk,
  input  logic             Reset_n,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] HS_BEGIN = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] VS_BEGIN = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_nxt_s;
  logic [9:0]       hc_r;
  logic [9:0]       vc_r;
  logic [9:0]       hc_nxt_s;
  logic [9:0]       vc_nxt_s;
  logic             pix_en_s;
  logic             h_wrap_s;
  logic             v_wrap_s;
  logic             frame_wrap_s;
  logic             vis_s;
  logic             hs_act_s;
  logic             vs_act_s;

  logic             vga_clk_r;
  logic             frame_start_r;
  logic             hs_r;
  logic             vs_r;
  logic             blank_n_r;
  logic [7:0]       red_r;
  logic [7:0]       green_r;
  logic [7:0]       blue_r;

  // Pixel-enable decode, next raster position and sync/visible decode of the current position.
  always_comb begin
    pix_en_s     = (div_r == DIV_LAST);
    h_wrap_s     = (hc_r == H_LAST);
    v_wrap_s     = (vc_r == V_LAST);
    frame_wrap_s = pix_en_s && h_wrap_s && v_wrap_s;
    vis_s        = (hc_r < H_VIS) && (vc_r < V_VIS);
    hs_act_s     = (hc_r >= HS_BEGIN) && (hc_r < HS_END);
    vs_act_s     = (vc_r >= VS_BEGIN) && (vc_r < VS_END);
    div_nxt_s    = div_r;
    hc_nxt_s     = hc_r;
    vc_nxt_s     = vc_r;

    if (pix_en_s) begin
      div_nxt_s = '0;
    end else begin
      div_nxt_s = div_r + DIV_ONE;
    end

    if (pix_en_s) begin
      if (h_wrap_s) begin
        hc_nxt_s = 10'd0;
        if (v_wrap_s) begin
          vc_nxt_s = 10'd0;
        end else begin
          vc_nxt_s = vc_r + 10'd1;
        end
      end else begin
        hc_nxt_s = hc_r + 10'd1;
        vc_nxt_s = vc_r;
      end
    end else begin
      hc_nxt_s = hc_r;
      vc_nxt_s = vc_r;
    end
  end

  // Clock divider and raster counters.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_r <= '0;
      hc_r  <= 10'd0;
      vc_r  <= 10'd0;
    end else begin
      div_r <= div_nxt_s;
      hc_r  <= hc_nxt_s;
      vc_r  <= vc_nxt_s;
    end
  end

  // DAC output stage: decoded from the pre-increment position, so pins lag DrawX/DrawY by one pixel.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vga_clk_r     <= 1'b0;
      frame_start_r <= 1'b0;
      hs_r          <= 1'b1;
      vs_r          <= 1'b1;
      blank_n_r     <= 1'b0;
      red_r         <= 8'h00;
      green_r       <= 8'h00;
      blue_r        <= 8'h00;
    end else begin
      vga_clk_r     <= (div_r >= DIV_HALF);
      frame_start_r <= frame_wrap_s;
      if (pix_en_s) begin
        hs_r      <= ~hs_act_s;
        vs_r      <= ~vs_act_s;
        blank_n_r <= vis_s;
        red_r     <= vis_s ? vga.Red   : 8'h00;
        green_r   <= vis_s ? vga.Green : 8'h00;
        blue_r    <= vis_s ? vga.Blue  : 8'h00;
      end
    end
  end

  assign vga.DrawX       = hc_r;
  assign vga.DrawY       = vc_r;
  assign vga.frame_start = frame_start_r;
  assign vga.VGA_CLK     = vga_clk_r;
  assign vga.VGA_HS      = hs_r;
  assign vga.VGA_VS      = vs_r;
  assign vga.VGA_BLANK_N = blank_n_r;
  assign vga.VGA_SYNC_N  = 1'b0;
  assign vga.VGA_R       = red_r;
  assign vga.VGA_G       = green_r;
  assign vga.VGA_B       = blue_r;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a shrunken raster (30x15 pixels, /2 divider)
// so full lines and frames fit in a short run.
module tb_vga_timing_gen;
  localparam int CLK_DIV   = 2;
  localparam int H_VISIBLE = 16;
  localparam int H_FRONT   = 4;
  localparam int H_SYNC    = 6;
  localparam int H_BACK    = 4;
  localparam int V_VISIBLE = 8;
  localparam int V_FRONT   = 2;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 3;
  localparam int H_TOTAL   = 30;
  localparam int V_TOTAL   = 15;
  localparam int LINE_CLK  = 60;
  localparam int FRAME_CLK = 900;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC),
    .H_BACK(H_BACK), .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC),
    .V_BACK(V_BACK)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .vga(vif)
  );

  always #5 Clk = ~Clk;

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wait_line_start(output bit ok);
    logic [9:0] prev;
    int n;
    ok = 1'b0; n = 0; prev = vif.DrawX;
    while (!ok && n < LINE_CLK + 4) begin
      step(1); n++;
      ok = (vif.DrawX == 10'd0) && (prev != 10'd0);
      prev = vif.DrawX;
    end
  endtask

  task automatic wait_frame_start(output bit ok);
    int n;
    n = 0; ok = (vif.frame_start == 1'b1);
    while (!ok && n < FRAME_CLK + 4) begin
      step(1); n++;
      ok = (vif.frame_start == 1'b1);
    end
  endtask

  task automatic test_reset();
    int fs_early;
    Reset_n = 1'b0;
    vif.Red = 8'hAB; vif.Green = 8'h5C; vif.Blue = 8'h31;
    step(3);
    checks++; if (vif.VGA_HS !== 1'b1) begin errors++; $display("FAIL reset_hs: got %b want 1", vif.VGA_HS); end
    checks++; if (vif.VGA_VS !== 1'b1) begin errors++; $display("FAIL reset_vs: got %b want 1", vif.VGA_VS); end
    checks++; if (vif.VGA_BLANK_N !== 1'b0) begin errors++; $display("FAIL reset_blank: got %b want 0", vif.VGA_BLANK_N); end
    checks++; if (vif.DrawX !== 10'd0 || vif.DrawY !== 10'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", vif.DrawX, vif.DrawY); end
    checks++; if (vif.VGA_R !== 8'h00 || vif.VGA_G !== 8'h00 || vif.VGA_B !== 8'h00) begin errors++; $display("FAIL reset_rgb: got %h%h%h want 000000", vif.VGA_R, vif.VGA_G, vif.VGA_B); end
    checks++; if (vif.VGA_CLK !== 1'b0 || vif.frame_start !== 1'b0) begin errors++; $display("FAIL reset_clk_fs: got %b%b want 00", vif.VGA_CLK, vif.frame_start); end
    checks++; if (vif.VGA_SYNC_N !== 1'b0) begin errors++; $display("FAIL sync_n: got %b want 0", vif.VGA_SYNC_N); end
    Reset_n = 1'b1;
    step(1);
    checks++; if (vif.DrawX !== 10'd0) begin errors++; $display("FAIL first_clk_x: got %0d want 0", vif.DrawX); end
    step(1);
    checks++; if (vif.DrawX !== 10'd1) begin errors++; $display("FAIL first_pix_x: got %0d want 1", vif.DrawX); end
    checks++; if (vif.VGA_CLK !== 1'b1) begin errors++; $display("FAIL first_vga_clk: got %b want 1", vif.VGA_CLK); end
    fs_early = 0;
    for (int i = 2; i < FRAME_CLK - 1; i++) begin
      step(1);
      if (vif.frame_start) fs_early++;
    end
    checks++; if (fs_early != 0) begin errors++; $display("FAIL first_frame_no_fs: got %0d pulses want 0", fs_early); end
    step(1);
    checks++; if (vif.frame_start !== 1'b1) begin errors++; $display("FAIL fs_after_frame: got %b want 1", vif.frame_start); end
    checks++; if (vif.DrawX !== 10'd0 || vif.DrawY !== 10'd0) begin errors++; $display("FAIL fs_xy: got %0d,%0d want 0,0", vif.DrawX, vif.DrawY); end
  endtask

  task automatic test_line();
    bit ok;
    int hs_low, blank_hi, clk_hi, first_hs_x, y0;
    wait_line_start(ok);
    checks++; if (!ok) begin errors++; $display("FAIL line_start_timeout: got none want wrap"); end
    hs_low = 0; blank_hi = 0; clk_hi = 0; first_hs_x = -1; y0 = int'(vif.DrawY);
    for (int s = 0; s < LINE_CLK; s++) begin
      if (s > 0) step(1);
      if (!vif.VGA_HS) begin
        hs_low++;
        if (first_hs_x < 0) first_hs_x = int'(vif.DrawX);
      end
      if (vif.VGA_BLANK_N) blank_hi++;
      if (vif.VGA_CLK) clk_hi++;
    end
    step(1);
    checks++; if (hs_low != H_SYNC * CLK_DIV) begin errors++; $display("FAIL hs_width: got %0d clk want %0d", hs_low, H_SYNC * CLK_DIV); end
    checks++; if (first_hs_x != 21) begin errors++; $display("FAIL hs_start_x: got %0d want 21", first_hs_x); end
    checks++; if (blank_hi != H_VISIBLE * CLK_DIV) begin errors++; $display("FAIL blank_width: got %0d want %0d", blank_hi, H_VISIBLE * CLK_DIV); end
    checks++; if (clk_hi != LINE_CLK / 2) begin errors++; $display("FAIL vga_clk_duty: got %0d want %0d", clk_hi, LINE_CLK / 2); end
    checks++; if (vif.DrawX !== 10'd0 || int'(vif.DrawY) != y0 + 1) begin errors++; $display("FAIL line_len: got %0d,%0d want 0,%0d", vif.DrawX, vif.DrawY, y0 + 1); end
  endtask

  task automatic test_frame();
    bit ok;
    int fs_cnt, vs_low, hs_low, vs_x, vs_y;
    wait_frame_start(ok);
    checks++; if (!ok) begin errors++; $display("FAIL frame_timeout: got none want frame_start"); end
    fs_cnt = 0; vs_low = 0; hs_low = 0; vs_x = -1; vs_y = -1;
    for (int s = 1; s <= FRAME_CLK; s++) begin
      step(1);
      if (vif.frame_start) fs_cnt++;
      if (!vif.VGA_HS) hs_low++;
      if (!vif.VGA_VS) begin
        vs_low++;
        if (vs_x < 0) begin vs_x = int'(vif.DrawX); vs_y = int'(vif.DrawY); end
      end
    end
    checks++; if (vif.frame_start !== 1'b1 || fs_cnt != 1) begin errors++; $display("FAIL fs_period: got %b/%0d want 1/1", vif.frame_start, fs_cnt); end
    checks++; if (vs_low != 120) begin errors++; $display("FAIL vs_width: got %0d want 120", vs_low); end
    checks++; if (vs_x != 1 || vs_y != 10) begin errors++; $display("FAIL vs_start: got %0d,%0d want 1,10", vs_x, vs_y); end
    checks++; if (hs_low != 180) begin errors++; $display("FAIL hs_frame: got %0d want 180", hs_low); end
  endtask

  task automatic test_color();
    bit ok, vis, hs_exp, vs_exp;
    int lx, ly, bad, r_ab, bad_x, bad_y;
    logic [7:0] er, eg, eb;
    wait_frame_start(ok);
    checks++; if (!ok) begin errors++; $display("FAIL color_timeout: got none want frame_start"); end
    bad = 0; r_ab = 0; bad_x = -1; bad_y = -1;
    for (int s = 0; s < FRAME_CLK; s++) begin
      if (s > 0) step(1);
      if (vif.DrawX == 10'd0) begin
        lx = H_TOTAL - 1;
        ly = (vif.DrawY == 10'd0) ? V_TOTAL - 1 : int'(vif.DrawY) - 1;
      end else begin
        lx = int'(vif.DrawX) - 1;
        ly = int'(vif.DrawY);
      end
      vis = (lx < H_VISIBLE) && (ly < V_VISIBLE);
      hs_exp = !((lx >= H_VISIBLE + H_FRONT) && (lx < H_VISIBLE + H_FRONT + H_SYNC));
      vs_exp = !((ly >= V_VISIBLE + V_FRONT) && (ly < V_VISIBLE + V_FRONT + V_SYNC));
      er = vis ? 8'hAB : 8'h00; eg = vis ? 8'h5C : 8'h00; eb = vis ? 8'h31 : 8'h00;
      if (vif.VGA_R === 8'hAB) r_ab++;
      if (vif.VGA_R !== er || vif.VGA_G !== eg || vif.VGA_B !== eb || vif.VGA_BLANK_N !== vis ||
          vif.VGA_HS !== hs_exp || vif.VGA_VS !== vs_exp) begin
        bad++;
        if (bad_x < 0) begin bad_x = lx; bad_y = ly; end
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL pixel_align: got %0d bad samples (first pixel %0d,%0d) want 0", bad, bad_x, bad_y); end
    checks++; if (r_ab != H_VISIBLE * V_VISIBLE * CLK_DIV) begin errors++; $display("FAIL red_count: got %0d want %0d", r_ab, H_VISIBLE * V_VISIBLE * CLK_DIV); end
    // Glitch Red between pixel enables; only the value present on the enable edge may land.
    step(1);
    step(6);
    checks++; if (vif.DrawX !== 10'd3 || vif.DrawY !== 10'd0) begin errors++; $display("FAIL glitch_pos: got %0d,%0d want 3,0", vif.DrawX, vif.DrawY); end
    vif.Red = 8'hFF;
    step(1);
    vif.Red = 8'hAB;
    step(1);
    checks++; if (vif.VGA_R !== 8'hAB) begin errors++; $display("FAIL glitch_ignored: got %h want ab", vif.VGA_R); end
    vif.Red = 8'h12;
    step(2);
    checks++; if (vif.VGA_R !== 8'h12) begin errors++; $display("FAIL color_sampled: got %h want 12", vif.VGA_R); end
    vif.Red = 8'hAB;
  endtask

  task automatic test_mid_reset();
    bit ok;
    int n, fs_early, hs_low, first_hs_x;
    n = 0; ok = 1'b0;
    while (!ok && n < 2 * FRAME_CLK) begin
      step(1); n++;
      ok = (vif.DrawX == 10'd12) && (vif.DrawY == 10'd5);
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_pos_timeout: got none want 12,5"); end
    checks++; if (vif.VGA_BLANK_N !== 1'b1 || vif.VGA_R !== 8'hAB) begin errors++; $display("FAIL mid_pre: got %b/%h want 1/ab", vif.VGA_BLANK_N, vif.VGA_R); end
    Reset_n = 1'b0;
    #1;
    checks++; if (vif.DrawX !== 10'd0 || vif.DrawY !== 10'd0) begin errors++; $display("FAIL mid_async_xy: got %0d,%0d want 0,0", vif.DrawX, vif.DrawY); end
    checks++; if (vif.VGA_BLANK_N !== 1'b0 || vif.VGA_R !== 8'h00 || vif.VGA_HS !== 1'b1 || vif.VGA_VS !== 1'b1) begin errors++; $display("FAIL mid_async_out: got %b/%h/%b/%b want 0/00/1/1", vif.VGA_BLANK_N, vif.VGA_R, vif.VGA_HS, vif.VGA_VS); end
    step(3);
    Reset_n = 1'b1;
    fs_early = 0; hs_low = 0; first_hs_x = -1;
    for (int s = 1; s < FRAME_CLK; s++) begin
      step(1);
      if (s == 2 && vif.DrawX !== 10'd1) begin
        errors++; $display("FAIL mid_first_pix: got %0d want 1", vif.DrawX);
      end
      if (vif.frame_start) fs_early++;
      if (s <= LINE_CLK && !vif.VGA_HS) begin
        hs_low++;
        if (first_hs_x < 0) first_hs_x = int'(vif.DrawX);
      end
    end
    checks++;
    checks++; if (fs_early != 0) begin errors++; $display("FAIL mid_no_early_fs: got %0d want 0", fs_early); end
    checks++; if (hs_low != 12 || first_hs_x != 21) begin errors++; $display("FAIL mid_full_hs: got %0d@%0d want 12@21", hs_low, first_hs_x); end
    step(1);
    checks++; if (vif.frame_start !== 1'b1) begin errors++; $display("FAIL mid_fs_period: got %b want 1", vif.frame_start); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_color();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
